// File: rtl/mu0_pkg.sv
// Shared MU0 constants: memory geometry, opcode values and loader FSM encoding.
package mu0_pkg;

   localparam int MAXWIDTH = 16;
   localparam int MAXDEPTH = 12;

   typedef enum logic [3:0] {
      LDA = 4'h0,
      STO = 4'h1,
      ADD = 4'h2,
      SUB = 4'h3,
      JMP = 4'h4,
      JGE = 4'h5,
      JNE = 4'h6,
      STP = 4'h7
   } opcode_t;

   typedef enum logic [1:0] {
      LOAD_HI = 2'd0,
      LOAD_LO = 2'd1,
      RUN     = 2'd2
   } state_t;

endpackage

// File: rtl/mu0_mem_if.sv
// Loader byte stream, core request/response and status signals of the MU0 memory.
interface mu0_mem_if #(
   parameter int MAXWIDTH = 16,
   parameter int MAXDEPTH = 12
);
   logic                ld_valid;
   logic [7:0]          ld_data;
   logic                ld_last;
   logic                ld_ready;
   logic                req_valid;
   logic                req_we;
   logic [MAXDEPTH-1:0] req_addr;
   logic [MAXWIDTH-1:0] req_wdata;
   logic                req_ready;
   logic                rsp_valid;
   logic [MAXWIDTH-1:0] rsp_data;
   logic                run;
   logic                ld_err;
   logic [MAXDEPTH-1:0] ld_words;

   modport master (
      output ld_valid, ld_data, ld_last, req_valid, req_we, req_addr, req_wdata,
      input  ld_ready, req_ready, rsp_valid, rsp_data, run, ld_err, ld_words
   );

   modport slave (
      input  ld_valid, ld_data, ld_last, req_valid, req_we, req_addr, req_wdata,
      output ld_ready, req_ready, rsp_valid, rsp_data, run, ld_err, ld_words
   );
endinterface

// File: rtl/mu0_ram.sv
// Synchronous single-port RAM, write-first, no reset on contents or read register.
module mu0_ram #(
   parameter int MAXWIDTH = 16,
   parameter int MAXDEPTH = 12
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [MAXDEPTH-1:0] i_addr,
   input  logic [MAXWIDTH-1:0] i_wdata,
   output logic [MAXWIDTH-1:0] o_rdata
);
   logic [MAXWIDTH-1:0] r_mem [2**MAXDEPTH];
   logic [MAXWIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
         r_rdata       <= i_wdata;
      end else begin
         r_rdata       <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/mu0_mem.sv
// MU0 memory: loads a big-endian byte image into RAM, then serves core reads/writes.
module mu0_mem #(
   parameter int MAXWIDTH = mu0_pkg::MAXWIDTH,
   parameter int MAXDEPTH = mu0_pkg::MAXDEPTH
) (
   input  logic     clk,
   input  logic     reset,
   mu0_mem_if.slave bus
);
   import mu0_pkg::*;

   state_t              r_state;
   logic [7:0]          r_hi;
   logic [MAXDEPTH-1:0] r_wptr;
   logic [MAXDEPTH-1:0] r_words;
   logic                r_err;
   logic                r_rsp_valid;
   logic [MAXWIDTH-1:0] r_rsp_last;

   logic                w_ram_we;
   logic [MAXDEPTH-1:0] w_ram_addr;
   logic [MAXWIDTH-1:0] w_ram_wdata;
   logic [MAXWIDTH-1:0] w_ram_q;

   // The single RAM port belongs to the loader until RUN, then to the core.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_addr  = r_wptr;
      w_ram_wdata = MAXWIDTH'({r_hi, bus.ld_data});
      if (r_state == RUN) begin
         w_ram_we    = bus.req_valid & bus.req_we;
         w_ram_addr  = bus.req_addr;
         w_ram_wdata = bus.req_wdata;
      end else if (r_state == LOAD_LO) begin
         w_ram_we    = bus.ld_valid;
      end
   end

   mu0_ram #(
      .MAXWIDTH (MAXWIDTH),
      .MAXDEPTH (MAXDEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= LOAD_HI;
         r_hi        <= '0;
         r_wptr      <= '0;
         r_words     <= '0;
         r_err       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (r_rsp_valid)
            r_rsp_last <= w_ram_q;
         case (r_state)
            LOAD_HI: begin
               if (bus.ld_valid) begin
                  // A last byte arriving as a high byte leaves a half word: drop it.
                  if (bus.ld_last) begin
                     r_err   <= 1'b1;
                     r_state <= RUN;
                  end else begin
                     r_hi    <= bus.ld_data;
                     r_state <= LOAD_LO;
                  end
               end
            end
            LOAD_LO: begin
               if (bus.ld_valid) begin
                  r_wptr  <= r_wptr + 1'b1;
                  r_words <= r_words + 1'b1;
                  r_state <= bus.ld_last ? RUN : LOAD_HI;
               end
            end
            RUN: begin
               r_rsp_valid <= bus.req_valid & ~bus.req_we;
            end
            default: r_state <= LOAD_HI;
         endcase
      end
   end

   // Read data is only fresh from the RAM on response cycles; otherwise replay the last one.
   assign bus.rsp_data  = r_rsp_valid ? w_ram_q : r_rsp_last;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.ld_ready  = (r_state != RUN);
   assign bus.req_ready = (r_state == RUN);
   assign bus.run       = (r_state == RUN);
   assign bus.ld_err    = r_err;
   assign bus.ld_words  = r_words;
endmodule
